// File: rtl/data_sd.sv
// SD card 4-bit data-line engine: receives or transmits one 512-byte block
// with per-line CRC16, write status response and busy handling.
module data_sd #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       istrobe,
  input  logic [3:0] idata_sd,
  output logic [3:0] odata_sd,
  output logic       ooe_sd,
  input  logic       istart_d_read,
  input  logic       istart_d_write,
  output logic [9:0] oaddr,
  output logic [3:0] owdata,
  output logic       owrite_en,
  input  logic [3:0] irdata,
  output logic       odata_done,
  output logic       odata_crc_fail,
  output logic       obusy
);

  typedef enum logic [3:0] {
    IDLE, R_WAIT, R_DATA, R_CRC, R_END,
    W_PRE, W_START, W_DATA, W_CRC, W_END, W_STAT, W_BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0][15:0] crc_q, crc_d;
  logic [3:0]       odata_q, odata_d;
  logic             ooe_q, ooe_d;
  logic [9:0]       oaddr_q, oaddr_d;
  logic [3:0]       owdata_q, owdata_d;
  logic             owrite_en_q, owrite_en_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [2:0]       stat_q, stat_d;
  logic             stat_go_q, stat_go_d;
  logic             finish, fail_now, timeout_hit;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign timeout_hit = ({1'b0, cnt_q} + 17'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    odata_d     = odata_q;
    ooe_d       = ooe_q;
    oaddr_d     = oaddr_q;
    owdata_d    = owdata_q;
    owrite_en_d = 1'b0;
    done_d      = 1'b0;
    fail_d      = fail_q;
    stat_d      = stat_q;
    stat_go_d   = stat_go_q;
    finish      = 1'b0;
    fail_now    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (istart_d_read || istart_d_write) begin
          state_d = istart_d_read ? R_WAIT : W_PRE;
          cnt_d   = '0;
          crc_d   = '0;
          fail_d  = 1'b0;
        end
      end
      R_WAIT: if (istrobe) begin
        if (idata_sd == 4'h0) begin
          state_d = R_DATA;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          fail_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_DATA: if (istrobe) begin
        owdata_d    = idata_sd;
        owrite_en_d = 1'b1;
        oaddr_d     = cnt_q[9:0];
        for (int unsigned i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], idata_sd[i]);
        if (cnt_q == 16'd1023) begin
          state_d = R_CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // Received CRC bits run through the same generator: a clean line leaves zero.
      R_CRC: if (istrobe) begin
        for (int unsigned i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], idata_sd[i]);
        if (cnt_q == 16'd15) begin
          state_d = R_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_END: if (istrobe) begin
        finish   = 1'b1;
        fail_now = (crc_q != '0) || (idata_sd != 4'hF);
      end
      W_PRE: if (istrobe) begin
        ooe_d   = 1'b1;
        odata_d = 4'hF;
        if (cnt_q == 16'd1) begin
          state_d = W_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      W_START: if (istrobe) begin
        odata_d = 4'h0;
        state_d = W_DATA;
      end
      W_DATA: if (istrobe) begin
        odata_d = irdata;
        oaddr_d = oaddr_q + 10'd1;
        for (int unsigned i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], irdata[i]);
        if (cnt_q == 16'd1023) begin
          state_d = W_CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      W_CRC: if (istrobe) begin
        odata_d = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};
        for (int unsigned i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
        if (cnt_q == 16'd15) begin
          state_d = W_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      W_END: if (istrobe) begin
        odata_d   = 4'hF;
        state_d   = W_STAT;
        cnt_d     = '0;
        stat_go_d = 1'b0;
      end
      W_STAT: if (istrobe) begin
        ooe_d   = 1'b0;
        odata_d = 4'hF;
        if (!stat_go_q) begin
          stat_go_d = !idata_sd[0];
          cnt_d     = '0;
        end else if (cnt_q < 16'd3) begin
          stat_d = {stat_q[1:0], idata_sd[0]};
          cnt_d  = cnt_q + 16'd1;
        end else if ((stat_q != 3'b010) || !idata_sd[0]) begin
          finish   = 1'b1;
          fail_now = 1'b1;
        end else begin
          state_d = W_BUSY;
          cnt_d   = '0;
        end
      end
      W_BUSY: if (istrobe) begin
        if (idata_sd[0]) begin
          finish = 1'b1;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          fail_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      done_d  = 1'b1;
      fail_d  = fail_now;
      ooe_d   = 1'b0;
      odata_d = 4'hF;
      oaddr_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      odata_q     <= 4'hF;
      ooe_q       <= 1'b0;
      oaddr_q     <= '0;
      owdata_q    <= '0;
      owrite_en_q <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      stat_q      <= '0;
      stat_go_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      odata_q     <= odata_d;
      ooe_q       <= ooe_d;
      oaddr_q     <= oaddr_d;
      owdata_q    <= owdata_d;
      owrite_en_q <= owrite_en_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      stat_q      <= stat_d;
      stat_go_q   <= stat_go_d;
    end
  end

  assign odata_sd       = odata_q;
  assign ooe_sd         = ooe_q;
  assign oaddr          = oaddr_q;
  assign owdata         = owdata_q;
  assign owrite_en      = owrite_en_q;
  assign odata_done     = done_q;
  assign odata_crc_fail = fail_q;
  assign obusy          = (state_q != IDLE);

endmodule

// File: tb/tb_data_sd.sv
// Scoreboard bench for data_sd: a card model drives strobed nibbles, a
// negedge monitor checks RAM writes, bus nibbles and done results.
module tb_data_sd;
  logic       iclk = 1'b0;
  logic       irst = 1'b1, istrobe = 1'b0;
  logic [3:0] idata_sd = 4'hF, irdata = 4'h0;
  logic       istart_d_read = 1'b0, istart_d_write = 1'b0;
  logic [3:0] odata_sd, owdata;
  logic       ooe_sd, owrite_en, odata_done, odata_crc_fail, obusy;
  logic [9:0] oaddr;

  initial forever #5 iclk = ~iclk;

  data_sd #(.TIMEOUT(16'd16)) dut (
    .iclk(iclk), .irst(irst), .istrobe(istrobe), .idata_sd(idata_sd),
    .odata_sd(odata_sd), .ooe_sd(ooe_sd), .istart_d_read(istart_d_read),
    .istart_d_write(istart_d_write), .oaddr(oaddr), .owdata(owdata),
    .owrite_en(owrite_en), .irdata(irdata), .odata_done(odata_done),
    .odata_crc_fail(odata_crc_fail), .obusy(obusy)
  );

  typedef struct packed { logic [9:0] a; logic [3:0] d; } wr_t;
  logic [3:0] ram [1024];
  logic [3:0] blk [1024];
  wr_t        exp_wr[$];
  logic [3:0] exp_bus[$];
  logic       exp_done[$];
  logic [3:0] card_q[$];
  int         n_cmp = 0, n_err = 0, done_seen = 0;
  logic       prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // Reference CRC: polynomial long division of one line's 1024 bits times x^16.
  function automatic logic [15:0] crc_ref(input int line);
    logic [1039:0] m;
    m = '0;
    for (int k = 0; k < 1024; k++) m[1039-k] = blk[k][line];
    for (int k = 0; k < 1024; k++)
      if (m[1039-k]) m[1039-k -: 17] = m[1039-k -: 17] ^ 17'h11021;
    return m[15:0];
  endfunction

  // Transmit RAM with one-cycle read latency.
  initial forever begin
    @(posedge iclk); #1;
    irdata = ram[oaddr];
  end

  // Monitor
  initial forever begin
    @(negedge iclk);
    if (!irst) begin
      if (owrite_en) begin
        if (exp_wr.size() == 0) fail_evt("wr_unexpected");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 32'(oaddr), 32'(w.a));
          check("wr_data", 32'(owdata), 32'(w.d));
        end
      end
      if (prev_strobe) begin
        if (ooe_sd) begin
          if (exp_bus.size() == 0) fail_evt("bus_unexpected");
          else begin
            logic [3:0] b;
            b = exp_bus.pop_front();
            check("bus", 32'(odata_sd), 32'(b));
          end
        end else check("idle_bus", 32'(odata_sd), 32'hF);
      end
      if (odata_done) begin
        done_seen++;
        if (exp_done.size() == 0) fail_evt("done_unexpected");
        else begin
          logic f;
          f = exp_done.pop_front();
          check("crc_fail", 32'(odata_crc_fail), 32'(f));
          check("done_ooe", 32'(ooe_sd), 32'h0);
          check("done_addr", 32'(oaddr), 32'h0);
          check("done_busy", 32'(obusy), 32'h0);
        end
      end
    end
    prev_strobe = istrobe;
  end

  initial begin
    repeat (95000) @(posedge iclk);
    $display("FAIL watchdog: simulation budget expired");
    $fatal(1);
  end

  task automatic strobe(input logic [3:0] d);
    @(posedge iclk); #1;
    idata_sd = d;
    istrobe  = 1'b1;
    @(posedge iclk); #1;
    istrobe = 1'b0;
    @(negedge iclk); #1;
    repeat ($urandom_range(0, 1)) @(posedge iclk);
  endtask

  task automatic start(input logic rd, input logic wr);
    @(posedge iclk); #1;
    istart_d_read  = rd;
    istart_d_write = wr;
    @(posedge iclk); #1;
    istart_d_read  = 1'b0;
    istart_d_write = 1'b0;
    @(negedge iclk);
    check("busy_after_start", 32'(obusy), 32'h1);
    check("fail_cleared", 32'(odata_crc_fail), 32'h0);
  endtask

  task automatic run_card(input int bound, input int d0);
    int steps;
    logic [3:0] nib;
    steps = 0;
    while (done_seen == d0 && steps < bound) begin
      nib = 4'hF;
      if (card_q.size() != 0) nib = card_q.pop_front();
      strobe(nib);
      steps++;
    end
    if (done_seen == d0) fail_evt("done_timeout");
    card_q.delete();
  endtask

  task automatic do_read(input logic [3:0] end_nib, input int flip_line,
                         input int n_idle, input logic both);
    logic [15:0] c [4];
    logic [3:0]  nib;
    int d0;
    for (int i = 0; i < 4; i++) c[i] = crc_ref(i);
    if (flip_line >= 0) c[flip_line][0] = ~c[flip_line][0];
    for (int k = 0; k < 1024; k++) exp_wr.push_back(wr_t'{a: 10'(k), d: blk[k]});
    exp_done.push_back((flip_line >= 0) || (end_nib != 4'hF));
    for (int k = 0; k < n_idle; k++) card_q.push_back(4'hF);
    card_q.push_back(4'h0);
    for (int k = 0; k < 1024; k++) card_q.push_back(blk[k]);
    for (int j = 0; j < 16; j++) begin
      nib = {c[3][15-j], c[2][15-j], c[1][15-j], c[0][15-j]};
      card_q.push_back(nib);
    end
    card_q.push_back(end_nib);
    d0 = done_seen;
    start(1'b1, both);
    run_card(1100 + n_idle, d0);
    check("wr_left", 32'(exp_wr.size()), 32'h0);
    check("done_left", 32'(exp_done.size()), 32'h0);
  endtask

  task automatic do_write(input logic [2:0] status, input int n_busy);
    logic [15:0] c [4];
    logic [3:0]  nib;
    int d0;
    for (int k = 0; k < 1024; k++) blk[k] = ram[k];
    for (int i = 0; i < 4; i++) c[i] = crc_ref(i);
    exp_bus.push_back(4'hF);
    exp_bus.push_back(4'hF);
    exp_bus.push_back(4'h0);
    for (int k = 0; k < 1024; k++) exp_bus.push_back(ram[k]);
    for (int j = 0; j < 16; j++) begin
      nib = {c[3][15-j], c[2][15-j], c[1][15-j], c[0][15-j]};
      exp_bus.push_back(nib);
    end
    exp_bus.push_back(4'hF);
    exp_done.push_back((status != 3'b010) || (n_busy >= 16));
    for (int k = 0; k < 1046; k++) card_q.push_back(4'hF);
    card_q.push_back(4'hE);
    for (int k = 2; k >= 0; k--) card_q.push_back({3'b111, status[k]});
    card_q.push_back(4'hF);
    for (int k = 0; k < n_busy; k++) card_q.push_back(4'hE);
    d0 = done_seen;
    start(1'b0, 1'b1);
    run_card(1100 + n_busy, d0);
    check("bus_left", 32'(exp_bus.size()), 32'h0);
    check("done_left", 32'(exp_done.size()), 32'h0);
  endtask

  initial begin
    int d0, n;
    logic [3:0] t;
    for (int k = 0; k < 1024; k++) ram[k] = 4'h0;
    repeat (3) @(posedge iclk);
    #1 irst = 1'b0;
    @(negedge iclk);
    check("rst_odata", 32'(odata_sd), 32'hF);
    check("rst_ooe", 32'(ooe_sd), 32'h0);
    check("rst_addr", 32'(oaddr), 32'h0);
    check("rst_wdata", 32'(owdata), 32'h0);
    check("rst_wen", 32'(owrite_en), 32'h0);
    check("rst_done", 32'(odata_done), 32'h0);
    check("rst_fail", 32'(odata_crc_fail), 32'h0);
    check("rst_busy", 32'(obusy), 32'h0);

    for (int k = 0; k < 1024; k++) blk[k] = 4'h0;
    do_read(4'hF, -1, 0, 1'b0);

    for (int k = 0; k < 1024; k++) blk[k] = 4'(k);
    do_read(4'hF, 2, 0, 1'b0);
    repeat (5) @(posedge iclk);
    @(negedge iclk);
    check("fail_held", 32'(odata_crc_fail), 32'h1);

    for (int k = 0; k < 1024; k++) blk[k] = 4'($urandom);
    do_read(4'hF, -1, 5, 1'b1);
    for (int k = 0; k < 1024; k++) blk[k] = 4'($urandom);
    do_read(4'h7, -1, 0, 1'b0);

    for (int k = 0; k < 1024; k++) begin
      t = 4'(k);
      ram[k] = ~t;
    end
    do_write(3'b010, 5);
    for (int k = 0; k < 1024; k++) ram[k] = 4'($urandom);
    do_write(3'b101, 5);
    do_write(3'b010, 15);
    do_write(3'b010, 16);

    exp_done.push_back(1'b1);
    d0 = done_seen;
    start(1'b1, 1'b0);
    n = 0;
    while (done_seen == d0 && n < 40) begin
      strobe(4'hF);
      n++;
    end
    check("timeout_strobes", 32'(n), 32'd16);
    check("done_left", 32'(exp_done.size()), 32'h0);

    for (int k = 0; k < 1024; k++) ram[k] = 4'($urandom);
    exp_bus.push_back(4'hF);
    exp_bus.push_back(4'hF);
    exp_bus.push_back(4'h0);
    for (int k = 0; k <= 500; k++) exp_bus.push_back(ram[k]);
    d0 = done_seen;
    start(1'b0, 1'b1);
    for (int k = 0; k < 504; k++) strobe(4'hF);
    @(posedge iclk); #1 irst = 1'b1;
    @(posedge iclk); #1 irst = 1'b0;
    @(negedge iclk);
    check("mid_rst_ooe", 32'(ooe_sd), 32'h0);
    check("mid_rst_odata", 32'(odata_sd), 32'hF);
    check("mid_rst_busy", 32'(obusy), 32'h0);
    check("mid_rst_addr", 32'(oaddr), 32'h0);
    check("mid_rst_done", 32'(odata_done), 32'h0);
    repeat (5) @(posedge iclk);
    check("mid_rst_no_done", 32'(done_seen), 32'(d0));
    check("bus_left", 32'(exp_bus.size()), 32'h0);

    for (int k = 0; k < 1024; k++) blk[k] = 4'($urandom);
    do_read(4'hF, -1, 3, 1'b0);

    repeat (4) @(posedge iclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_sd.md
DATA_SD -- requirements
Module: data_sd

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, meaning strobes to wait for a read start bit or for busy release before failing.
REQ-002 SHALL have port iclk, input, 1, system clock (36 MHz); the block uses this one clock only.
REQ-003 SHALL have port irst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port istrobe, input, 1, one-iclk pulse per SD clock period; consecutive pulses are at least 2 iclk apart.
REQ-005 SHALL have port idata_sd, input, 4, D[3:0] from card.
REQ-006 SHALL have port odata_sd, output, 4, D[3:0] to card.
REQ-007 SHALL have port ooe_sd, output, 1, D-line output enable.
REQ-008 SHALL have ports istart_d_read and istart_d_write, input, 1 each, one-cycle start pulses.
REQ-009 SHALL have port oaddr, output, 10, nibble address in RAM (0..1023).
REQ-010 SHALL have ports owdata (output, 4) and owrite_en (output, 1), received-nibble RAM write.
REQ-011 SHALL have port irdata, input, 4, transmit RAM data, valid 1 iclk after oaddr.
REQ-012 SHALL have ports odata_done (output, 1, one-cycle end pulse), odata_crc_fail (output, 1, valid with done) and obusy (output, 1, level, high when not IDLE).

Function
REQ-013 SHALL, on istrobe in any enabled state, act only on strobe edges: sample idata_sd and update odata_sd on istrobe cycles only.
REQ-014 SHALL implement states IDLE, R_WAIT, R_DATA, R_CRC, R_END, W_PRE, W_START, W_DATA, W_CRC, W_END, W_STAT, W_BUSY.
REQ-015 SHALL, in IDLE, leave on istart_d_read to R_WAIT and on istart_d_write to W_PRE; when both are asserted, read wins; starts outside IDLE are ignored.
REQ-016 SHALL, in R_WAIT, go to R_DATA on the first strobe with idata_sd == 4'h0, and SHALL fail after TIMEOUT strobes without a start bit.
REQ-017 SHALL, in R_DATA, capture 1024 nibbles on successive strobes, writing nibble k to oaddr k with owrite_en high for exactly one iclk, on the strobe cycle +1.
REQ-018 SHALL compute an independent CRC16 (x^16+x^12+x^5+1, init 0) per line over the 1024 data bits, with D3 as bit 3 of each nibble.
REQ-019 SHALL, in R_CRC, shift in 16 bits per line, MSB first, then check the end bit in R_END.
REQ-020 SHALL fail a read on any CRC mismatch or on an end bit != 4'hF.
REQ-021 SHALL, in W_PRE, drive ooe_sd=1 and odata_sd=4'hF for 2 strobes, then drive 4'h0 for 1 strobe in W_START.
REQ-022 SHALL, in W_DATA, send 1024 nibbles in order 0..1023; oaddr advances to k+1 on the strobe that drives nibble k, and irdata is taken at the next strobe.
REQ-023 SHALL, in W_CRC, send the 16-bit per-line CRCs MSB first.
REQ-024 SHALL, in W_END, drive 4'hF for 1 strobe, then set ooe_sd=0.
REQ-025 SHALL, in W_STAT, wait for D0=0, sample 3 status bits plus the end bit; status != 3'b010 or end bit != 1 is a fail.
REQ-026 SHALL, in W_BUSY, wait for D0=1; on TIMEOUT strobes it fails; on D0=1 it goes to IDLE.
REQ-027 SHALL, on completion or fail, pulse odata_done for one iclk with odata_crc_fail (1 = fail) held until the next start, return to IDLE with ooe_sd=0, and set oaddr to 0.
REQ-028 SHALL hold odata_sd=4'hF whenever ooe_sd=0.

Reset
REQ-029 SHALL, while irst=1 (including mid-transfer), enter IDLE with odata_sd=4'hF, ooe_sd=0, oaddr=0, owdata=0, owrite_en=0, odata_done=0, odata_crc_fail=0, obusy=0, CRCs and counters cleared, and no done pulse.

Verification
REQ-030 SHALL pass the read of a zero block: start bit, 1024x4'h0, CRC 0x0000 per line, end 4'hF -> 1024 writes of 4'h0 at addresses 0..1023, done=1, crc_fail=0.
REQ-031 SHALL pass the read of an incrementing block (nibble k = k[3:0]) with a model CRC whose D2 CRC bit 0 is flipped -> RAM contents correct, done=1, crc_fail=1.
REQ-032 SHALL pass the write of RAM nibble k = ~k[3:0] -> bus shows 2x4'hF, 4'h0, data, model CRCs, 4'hF; then card status 0 010 1 plus 5 busy strobes -> done=1, crc_fail=0.
REQ-033 SHALL pass a write with card status 0 101 1 -> done=1, crc_fail=1.
REQ-034 SHALL pass a read with TIMEOUT=16 and no start bit -> done at strobe 16, crc_fail=1, ooe_sd=0.
REQ-035 SHALL pass irst asserted at nibble 500 of a write -> next cycle: IDLE, ooe_sd=0, odata_sd=4'hF, no done pulse; a subsequent read completes normally.
